// File: rtl/x_capture_pkg.sv
// Shared types for the multi-channel capture arbiter: FSM state encoding and
// the channel-index width helper used by every file of the block.
package x_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } cap_state_e;

    localparam int HOLD_W = 8;

    // A single-channel build still needs a one-bit channel index.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/x_capture_arbiter_if.sv
// Trigger/readback bus of the capture arbiter. The slave modport is the arbiter;
// CAP_TS and TS_W exist only when CAPTURE_TIMESTAMP_EN is defined.
interface x_capture_arbiter_if
    import x_capture_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
`ifdef CAPTURE_TIMESTAMP_EN
    ,
    parameter int TS_W   = 32
`endif
) ();

    localparam int CH_W = ch_w(NUM_CH);

    // Handshake: CAP_REQ holds with a stable CAP_CH until the cycle CAP_ACK=1 is
    // sampled; that clock completes the transfer and CAP_REQ drops right after it.
    logic [NUM_CH-1:0] CAP;
    logic [NUM_CH-1:0] REARM;
    logic              CAP_ACK;
    logic              CAP_REQ;
    logic [CH_W-1:0]   CAP_CH;
    logic [NUM_CH-1:0] ARMED;
    logic              BUSY;
    logic [CNT_W-1:0]  CAP_CNT;
    cap_state_e        DBG_STATE;
`ifdef CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0]   CAP_TS;

    modport master (
        output CAP, REARM, CAP_ACK,
        input  CAP_REQ, CAP_CH, ARMED, BUSY, CAP_CNT, DBG_STATE, CAP_TS
    );

    modport slave (
        input  CAP, REARM, CAP_ACK,
        output CAP_REQ, CAP_CH, ARMED, BUSY, CAP_CNT, DBG_STATE, CAP_TS
    );
`else
    modport master (
        output CAP, REARM, CAP_ACK,
        input  CAP_REQ, CAP_CH, ARMED, BUSY, CAP_CNT, DBG_STATE
    );

    modport slave (
        input  CAP, REARM, CAP_ACK,
        output CAP_REQ, CAP_CH, ARMED, BUSY, CAP_CNT, DBG_STATE
    );
`endif

endinterface

// File: rtl/x_capture_rr_pick.sv
// Combinational round-robin picker: lowest-index pending channel at or after
// ptr_i, wrapping around NUM_CH.
module x_capture_rr_pick
    import x_capture_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pend_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [CH_W-1:0]   gnt_o,
    output logic              vld_o
);

    localparam int IW = CH_W + 1;

    logic [IW-1:0] idx;

    // Scan from the farthest offset down so the nearest pending channel wins last.
    always_comb begin
        gnt_o = '0;
        vld_o = 1'b0;
        idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_i} + IW'(k);
            if (idx >= IW'(NUM_CH)) begin
                idx = idx - IW'(NUM_CH);
            end
            if (pend_i[idx[CH_W-1:0]]) begin
                gnt_o = idx[CH_W-1:0];
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/x_capture_arbiter.sv
// Multi-channel capture trigger arbiter: edge-detects NUM_CH triggers and grants
// them round-robin to one readback engine. Optional CAPTURE_TIMESTAMP_EN adds CAP_TS.
module x_capture_arbiter
    import x_capture_pkg::*;
#(
    parameter int                NUM_CH       = 4,
    parameter logic [NUM_CH-1:0] ONESHOT_MASK = {NUM_CH{1'b1}},
    parameter int                HOLDOFF      = 8,
    parameter int                CNT_W        = 8
`ifdef CAPTURE_TIMESTAMP_EN
    ,
    parameter int                TS_W         = 32
`endif
) (
    input logic               CLK,
    input logic               RST,
    x_capture_arbiter_if.slave bus
);

    localparam int                CH_W      = ch_w(NUM_CH);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = (HOLDOFF > 0) ? HOLD_W'(HOLDOFF - 1) : '0;

    logic [NUM_CH-1:0] cap_q;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] armed_q, armed_d;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] gnt_oh;

    cap_state_e        state_q;
    logic              req_q;
    logic              busy_q;
    logic [CH_W-1:0]   ch_q;
    logic [CH_W-1:0]   ptr_q;
    logic [HOLD_W-1:0] hcnt_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [CH_W-1:0]   pick_gnt;
    logic              pick_vld;
    logic              grant;

    x_capture_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .pend_i (pend_q),
        .ptr_i  (ptr_q),
        .gnt_o  (pick_gnt),
        .vld_o  (pick_vld)
    );

    assign grant = (state_q == IDLE) && pick_vld;
    assign rise  = bus.CAP & ~cap_q;

    always_comb begin
        gnt_oh = '0;
        if (grant) begin
            gnt_oh[pick_gnt] = 1'b1;
        end
    end

    // A fresh edge in the grant cycle re-pends its channel; REARM beats a same-cycle disarm.
    always_comb begin
        pend_d  = (pend_q & ~gnt_oh) | (rise & armed_q);
        armed_d = (armed_q & ~(gnt_oh & ONESHOT_MASK)) | bus.REARM | ~ONESHOT_MASK;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_q   <= bus.CAP;
            pend_q  <= '0;
            armed_q <= '1;
        end else begin
            cap_q   <= bus.CAP;
            pend_q  <= pend_d;
            armed_q <= armed_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            ch_q    <= '0;
            ptr_q   <= '0;
            hcnt_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        ch_q    <= pick_gnt;
                        ptr_q   <= (pick_gnt == LAST_CH) ? '0 : pick_gnt + 1'b1;
                    end
                end
                REQ: begin
                    if (bus.CAP_ACK) begin
                        req_q <= 1'b0;
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (HOLDOFF > 0) begin
                            state_q <= HOLD;
                            hcnt_q  <= HOLD_INIT;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (hcnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hcnt_q <= hcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] cap_ts_q;

    // Stamp taken on the clock that leaves IDLE, i.e. one after the trigger edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ts_cnt_q <= '0;
            cap_ts_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
            if (grant) begin
                cap_ts_q <= ts_cnt_q;
            end
        end
    end

    assign bus.CAP_TS = cap_ts_q;
`endif

    assign bus.CAP_REQ   = req_q;
    assign bus.CAP_CH    = ch_q;
    assign bus.ARMED     = armed_q;
    assign bus.BUSY      = busy_q;
    assign bus.CAP_CNT   = cnt_q;
    assign bus.DBG_STATE = state_q;

endmodule

// File: tb/tb_x_capture_arbiter.sv
// Bench for x_capture_arbiter: two instances (no hold-off / all one-shot, and
// hold-off 5 / mixed modes / 2-bit counter) against a behavioural model.
`timescale 1ns/1ps
module tb_x_capture_arbiter;
    import x_capture_pkg::*;

    localparam int             N      = 4;
    localparam logic [N-1:0]   OSM_A  = 4'b1111;
    localparam int             HOLD_A = 0;
    localparam int             CNTW_A = 8;
    localparam logic [N-1:0]   OSM_B  = 4'b0101;
    localparam int             HOLD_B = 5;
    localparam int             CNTW_B = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    bit   chk_en = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef CAPTURE_TIMESTAMP_EN
    x_capture_arbiter_if #(.NUM_CH(N), .CNT_W(CNTW_A), .TS_W(32)) ifa ();
    x_capture_arbiter_if #(.NUM_CH(N), .CNT_W(CNTW_B), .TS_W(32)) ifb ();
    x_capture_arbiter #(.NUM_CH(N), .ONESHOT_MASK(OSM_A), .HOLDOFF(HOLD_A), .CNT_W(CNTW_A), .TS_W(32))
        u_a (.CLK(clk), .RST(rst_a), .bus(ifa.slave));
    x_capture_arbiter #(.NUM_CH(N), .ONESHOT_MASK(OSM_B), .HOLDOFF(HOLD_B), .CNT_W(CNTW_B), .TS_W(32))
        u_b (.CLK(clk), .RST(rst_b), .bus(ifb.slave));
`else
    x_capture_arbiter_if #(.NUM_CH(N), .CNT_W(CNTW_A)) ifa ();
    x_capture_arbiter_if #(.NUM_CH(N), .CNT_W(CNTW_B)) ifb ();
    x_capture_arbiter #(.NUM_CH(N), .ONESHOT_MASK(OSM_A), .HOLDOFF(HOLD_A), .CNT_W(CNTW_A))
        u_a (.CLK(clk), .RST(rst_a), .bus(ifa.slave));
    x_capture_arbiter #(.NUM_CH(N), .ONESHOT_MASK(OSM_B), .HOLDOFF(HOLD_B), .CNT_W(CNTW_B))
        u_b (.CLK(clk), .RST(rst_b), .bus(ifb.slave));
`endif

    // ---------------- behavioural model ----------------
    // phase: 0 waiting for work, 1 request outstanding, 2 hold-off running.
    typedef struct {
        logic [N-1:0] cap_prev;
        logic [N-1:0] pend;
        logic [N-1:0] armed;
        int           phase;
        int           hold_left;
        int           ptr;
        int           ch;
        int           cnt;
        int unsigned  ts_now;
        int unsigned  ts;
    } model_t;

    model_t ma, mb;

    function automatic model_t mstep(model_t m, logic [N-1:0] osm, int hold, int cnt_max,
                                     logic rst, logic [N-1:0] cap, logic [N-1:0] rearm, logic ack);
        model_t       n;
        logic [N-1:0] rise;
        int           c;
        n = m;
        if (rst) begin
            n.cap_prev = cap; n.pend = '0; n.armed = '1; n.phase = 0; n.hold_left = 0;
            n.ptr = 0; n.ch = 0; n.cnt = 0; n.ts_now = 0; n.ts = 0;
            return n;
        end
        n.ts_now = m.ts_now + 1;
        rise = cap & ~m.cap_prev;
        if (m.phase == 0 && m.pend != '0) begin
            for (int k = 0; k < N; k++) begin
                c = (m.ptr + k) % N;
                if (m.pend[c]) begin
                    n.ch = c;
                    break;
                end
            end
            n.pend[n.ch] = 1'b0;
            if (osm[n.ch]) n.armed[n.ch] = 1'b0;
            n.ptr   = (n.ch + 1) % N;
            n.phase = 1;
            n.ts    = m.ts_now;
        end else if (m.phase == 1 && ack) begin
            n.cnt = (m.cnt < cnt_max) ? m.cnt + 1 : m.cnt;
            if (hold > 0) begin
                n.phase = 2;
                n.hold_left = hold;
            end else begin
                n.phase = 0;
            end
        end else if (m.phase == 2) begin
            n.hold_left = m.hold_left - 1;
            if (n.hold_left == 0) n.phase = 0;
        end
        n.pend     = n.pend | (rise & m.armed);
        n.armed    = n.armed | rearm | ~osm;
        n.cap_prev = cap;
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= mstep(ma, OSM_A, HOLD_A, (1 << CNTW_A) - 1, rst_a, ifa.CAP, ifa.REARM, ifa.CAP_ACK);
        mb <= mstep(mb, OSM_B, HOLD_B, (1 << CNTW_B) - 1, rst_b, ifb.CAP, ifb.REARM, ifb.CAP_ACK);
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_req",   ifa.CAP_REQ, ma.phase == 1);
            check("a_busy",  ifa.BUSY,    ma.phase != 0);
            check("a_armed", ifa.ARMED,   ma.armed);
            check("a_cnt",   ifa.CAP_CNT, ma.cnt);
            if (ma.phase == 1) check("a_ch", ifa.CAP_CH, ma.ch);
            check("b_req",   ifb.CAP_REQ, mb.phase == 1);
            check("b_busy",  ifb.BUSY,    mb.phase != 0);
            check("b_armed", ifb.ARMED,   mb.armed);
            check("b_cnt",   ifb.CAP_CNT, mb.cnt);
            if (mb.phase == 1) check("b_ch", ifb.CAP_CH, mb.ch);
`ifdef CAPTURE_TIMESTAMP_EN
            check("a_ts", ifa.CAP_TS, ma.ts);
            check("b_ts", ifb.CAP_TS, mb.ts);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_req_b(input int budget, input string name);
        int i;
        i = 0;
        while (!ifb.CAP_REQ && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, ifb.CAP_REQ, 1);
    endtask

    task automatic record_grants_a(input int ncyc, output logic [31:0] chs[$], output int cycs[$]);
        chs.delete();
        cycs.delete();
        repeat (ncyc) begin
            @(negedge clk);
            if (ifa.CAP_REQ) begin
                chs.push_back(32'(ifa.CAP_CH));
                cycs.push_back(cyc);
            end
        end
    endtask

    task automatic record_grants_b(input int ncyc, output logic [31:0] chs[$], output int cycs[$]);
        chs.delete();
        cycs.delete();
        repeat (ncyc) begin
            @(negedge clk);
            if (ifb.CAP_REQ && (chs.size() == 0 || cycs[cycs.size()-1] != cyc - 1)) begin
                chs.push_back(32'(ifb.CAP_CH));
                cycs.push_back(cyc);
            end
        end
    endtask

    task automatic compare_grants(input string name, input logic [31:0] exp_q[$],
                                  input logic [31:0] chs[$], input int cycs[$], input int gap);
        check({name, "_count"}, chs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check({name, "_ch"}, (i < chs.size()) ? chs[i] : 32'hFFFF_FFFF, exp_q[i]);
            if (i > 0 && i < cycs.size()) check({name, "_gap"}, cycs[i] - cycs[i-1], gap);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] got_ch[$];
        int          got_cyc[$];
        bit          seen;

        ifa.CAP = '0; ifa.REARM = '0; ifa.CAP_ACK = 1'b0;
        ifb.CAP = '0; ifb.REARM = '0; ifb.CAP_ACK = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        // reset values
        check("rst_req",   ifa.CAP_REQ, 0);
        check("rst_busy",  ifa.BUSY,    0);
        check("rst_armed", ifa.ARMED,   4'b1111);
        check("rst_cnt",   ifa.CAP_CNT, 0);
        check("rst_ch",    ifa.CAP_CH,  0);

        // single one-shot trigger, ACK tied high, two-clock latency
        ifa.CAP_ACK = 1'b1;
        ifa.CAP = 4'b0100;
        @(negedge clk);
        check("os_latency", ifa.CAP_REQ, 0);
        @(negedge clk);
        check("os_req", ifa.CAP_REQ, 1);
        check("os_ch",  ifa.CAP_CH,  2);
        @(negedge clk);
        check("os_req_one_cycle", ifa.CAP_REQ, 0);
        check("os_armed",         ifa.ARMED,   4'b1011);
        check("os_cnt",           ifa.CAP_CNT, 1);
        ifa.CAP = 4'b0000;
        @(negedge clk);
        ifa.CAP = 4'b0100;
        repeat (4) begin
            @(negedge clk);
            check("os_disarmed_noreq", ifa.CAP_REQ, 0);
        end
        ifa.REARM = 4'b0100;
        @(negedge clk);
        ifa.REARM = 4'b0000;
        ifa.CAP = 4'b0000;
        check("os_rearmed", ifa.ARMED, 4'b1111);
        @(negedge clk);
        ifa.CAP = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        check("os_rearm_req", ifa.CAP_REQ, 1);
        check("os_rearm_ch",  ifa.CAP_CH,  2);
        @(negedge clk);

        // round-robin from a fresh pointer, no hold-off
        ifa.CAP = 4'b0000;
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        ifa.CAP = 4'b1011;
        record_grants_a(12, got_ch, got_cyc);
        exp_q = '{32'd0, 32'd1, 32'd3};
        compare_grants("rr", exp_q, got_ch, got_cyc, 2);

        // stalled ACK
        ifa.CAP = 4'b0000;
        ifa.CAP_ACK = 1'b0;
        @(negedge clk);
        ifa.CAP = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        repeat (10) begin
            check("stall_req", ifa.CAP_REQ, 1);
            check("stall_ch",  ifa.CAP_CH,  2);
            check("stall_cnt", ifa.CAP_CNT, 3);
            @(negedge clk);
        end
        ifa.CAP_ACK = 1'b1;
        @(negedge clk);
        check("stall_release", ifa.CAP_REQ, 0);
        check("stall_cnt_inc", ifa.CAP_CNT, 4);

        // reset while a request is outstanding, trigger held high through reset
        ifa.REARM = 4'b1111;
        @(negedge clk);
        ifa.REARM = 4'b0000;
        ifa.CAP_ACK = 1'b0;
        ifa.CAP = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        check("abort_req_up", ifa.CAP_REQ, 1);
        check("abort_ch",     ifa.CAP_CH,  0);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("abort_req",   ifa.CAP_REQ, 0);
        check("abort_busy",  ifa.BUSY,    0);
        check("abort_cnt",   ifa.CAP_CNT, 0);
        check("abort_armed", ifa.ARMED,   4'b1111);
        check("abort_ch0",   ifa.CAP_CH,  0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ifa.CAP_REQ) seen = 1'b1;
        end
        check("held_level_no_req", seen, 0);
        ifa.CAP_ACK = 1'b1;
        ifa.CAP = 4'b0000;

        // hold-off of 5 between two continuous channels
        ifb.CAP_ACK = 1'b1;
        ifb.CAP = 4'b1010;
        record_grants_b(24, got_ch, got_cyc);
        exp_q = '{32'd1, 32'd3};
        compare_grants("hold", exp_q, got_ch, got_cyc, 7);

        // 2-bit counter saturation
        ifb.CAP = 4'b0000;
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ifb.CAP = 4'b0010;
            wait_req_b(30, "sat_req");
            @(negedge clk);
            ifb.CAP = 4'b0000;
            if (i == 1) check("sat_cnt_two", ifb.CAP_CNT, 2);
            @(negedge clk);
        end
        check("sat_cnt", ifb.CAP_CNT, 3);
        repeat (8) @(negedge clk);

`ifdef CAPTURE_TIMESTAMP_EN
        // edge sampled while the free-running counter reads 100
        ifa.CAP = 4'b0000;
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (100) @(negedge clk);
        ifa.CAP = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        check("ts_latch", ifa.CAP_TS, 101);
        repeat (5) @(negedge clk);
        check("ts_hold", ifa.CAP_TS, 101);
        ifa.CAP = 4'b0000;
`endif

        // randomized traffic on both instances
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst_a = ($urandom_range(0, 199) == 0);
            rst_b = ($urandom_range(0, 199) == 0);
            ifa.CAP     = N'($urandom_range(0, 15));
            ifb.CAP     = N'($urandom_range(0, 15));
            ifa.REARM   = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 15)) : '0;
            ifb.REARM   = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 15)) : '0;
            ifa.CAP_ACK = ($urandom_range(0, 3) != 0);
            ifb.CAP_ACK = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/x_capture_arbiter.md
# x_capture_arbiter

Multi-channel successor to the single-trigger readback capture primitive. It accepts NUM_CH independent capture triggers and detects their rising edges. Each channel runs in one-shot or continuous mode and can be re-armed. Pending captures are granted round-robin to one downstream readback engine over a REQ/ACK handshake, with a programmable hold-off between captures. It sits between user trigger logic and the configuration readback controller in simulation models and in the soft capture path.

## Interface
- NUM_CH, 4: number of capture channels, 1..16.
- ONESHOT_MASK, {NUM_CH{1'b1}}: per-channel mode; bit=1 one-shot, bit=0 continuous.
- HOLDOFF, 8: idle cycles forced after each acknowledged capture, 0..255.
- CNT_W, 8: width of the saturating capture counter.
- TS_W, 32: timestamp width (used only with the macro).
- CLK  in  1  sole clock, all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- CAP  in  NUM_CH  capture triggers, level inputs, rising edge requests a capture.
- REARM  in  NUM_CH  one-cycle pulse re-arms the corresponding one-shot channel.
- CAP_REQ  out  1  capture request to the readback engine.
- CAP_CH  out  max(1,$clog2(NUM_CH))  channel granted, valid while CAP_REQ=1.
- CAP_ACK  in  1  readback engine accepts the current request.
- ARMED  out  NUM_CH  channel armed status.
- BUSY  out  1  FSM not in IDLE.
- CAP_CNT  out  CNT_W  total acknowledged captures, saturating.

## Operation
- Edge detect: a rising edge on channel i is CAP[i]=1 with registered cap_q[i]=0. During RST, cap_q loads CAP, so a level held high through reset produces no edge.
- Pending: on a rising edge with ARMED[i]=1, pend[i] is set. Edges on disarmed channels are dropped. pend[i] clears when channel i is granted.
- FSM states:
  - IDLE: when any pend bit is set, pick the lowest-index pending channel at or after ptr, wrapping. Latch it into CAP_CH, clear its pend bit, disarm it if one-shot, set ptr to granted+1 mod NUM_CH, go to REQ.
  - REQ: CAP_REQ=1 and CAP_CH stable. On CAP_ACK=1, CAP_CNT increments (holds at all-ones). Go to HOLD if HOLDOFF>0, else IDLE.
  - HOLD: counter loads HOLDOFF-1 on entry and counts to 0, then go to IDLE. Triggers continue to set pend during HOLD.
- CAP_ACK outside REQ is ignored.
- A continuous channel may re-pend while its own request is in REQ or HOLD. It is served again only after hold-off, and round-robin moves past it first if others are pending.
- REARM[i] sets ARMED[i] on the next clock. An edge in the same cycle as REARM on a disarmed channel is dropped. REARM on a continuous channel has no effect; continuous channels are always armed.
- Reset values: CAP_REQ=0, CAP_CH=0, BUSY=0, CAP_CNT=0, ARMED all 1, pend=0, ptr=0, FSM=IDLE. Asserting RST in REQ or HOLD aborts immediately with no count increment.

## Timing
- CAP first sampled high at clock n sets pend at n. CAP_REQ rises after clock n+1, a two-clock latency from an idle state.
- CAP_REQ falls on the clock that samples CAP_ACK=1, a single-cycle grant when ACK is already high.
- Minimum spacing between consecutive CAP_REQ assertions: 2+HOLDOFF clocks.
- All outputs are registered.

## Configuration
- CAPTURE_TIMESTAMP_EN:
  - Defined: adds a TS_W free-running counter (reset 0, wraps) and output CAP_TS[TS_W-1:0]. CAP_TS latches the counter value at the cycle the FSM leaves IDLE and holds it until the next grant; reset value 0.
  - Undefined: the counter and the port are absent, and behaviour is otherwise identical.

## Structure
- Shared package x_capture_pkg holds the FSM state enum (IDLE, REQ, HOLD) and the function computing CAP_CH width.
- One sub-module, x_capture_rr_pick: combinational round-robin picker taking pend and ptr, returning a grant index and a valid flag.

## Test plan
- Single one-shot trigger: NUM_CH=4, CAP[2] rises, ACK tied high. Expect CAP_REQ for exactly one cycle with CAP_CH=2, ARMED=4'b1011, CAP_CNT=1. A second CAP[2] edge produces no request until REARM[2] is pulsed.
- Round-robin: CAP[0], CAP[1] and CAP[3] rise together, HOLDOFF=0. Expect grants 0, 1, 3 in order, each 2 clocks apart.
- Hold-off: HOLDOFF=5, two continuous channels pending. Expect CAP_REQ assertions spaced 7 clocks apart.
- Stalled ACK: hold CAP_ACK=0 for 10 cycles. Expect CAP_REQ and CAP_CH stable throughout and the count unchanged. The request drops the cycle after ACK=1.
- Saturation and reset: CNT_W=2, 5 acknowledged captures give CAP_CNT=3. RST asserted during REQ clears all outputs next clock. With CAP held high through reset, no request is issued afterwards.
- With CAPTURE_TIMESTAMP_EN defined: CAP[1] edge at counter value 100. Expect CAP_TS=101, the value at the IDLE exit, held until the next grant.
